// File: rtl/riscv_mem_io.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_io
// Purpose  : Word RAM plus MMIO page (LED, 8N1 UART TX, optional cycle timer)
//            for the multicycle RV32 core. Registered ReadData, 1-cycle latency.
// Options  : define MMIO_TIMER_EN to include the free-running timer at 0x1000_000C.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_io #(
    parameter int MEM_WORDS    = 1024,
    parameter int CLKS_PER_BIT = 434,
    parameter     INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [29:0] A_LED  = 30'h0400_0000;
    localparam logic [29:0] A_UDAT = 30'h0400_0001;
    localparam logic [29:0] A_USTA = 30'h0400_0002;
`ifdef MMIO_TIMER_EN
    localparam logic [29:0] A_TIMER = 30'h0400_0003;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   ram_rd_q;
    logic          ram_sel_q;
    logic [31:0]   mmio_q, mmio_d;
    logic [7:0]    leds_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic          ram_sel;
    logic [AW-1:0] ram_idx;
    logic          busy;
    logic          uart_wr;
    logic          bit_end;

    assign ram_sel = (Address < 32'(MEM_WORDS * 4));
    assign ram_idx = Address[AW+1:2];
    assign busy    = (state_q != S_IDLE);
    assign uart_wr = MemWrite && (Address[31:2] == A_UDAT) && !busy;
    assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

    // RAM is not reset; the read returns the pre-write contents on a same-cycle R/W.
    always_ff @(posedge clk) begin
        if (MemWrite && ram_sel) mem[ram_idx] <= WriteData;
        ram_rd_q <= mem[ram_idx];
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] timer_q;

    always_ff @(posedge clk) begin
        if (reset)                                        timer_q <= 32'd0;
        else if (MemWrite && (Address[31:2] == A_TIMER)) timer_q <= 32'd0;
        else                                              timer_q <= timer_q + 32'd1;
    end
`endif

    always_comb begin
        mmio_d = 32'd0;
        case (Address[31:2])
            A_LED:   mmio_d = {24'd0, leds_q};
            A_USTA:  mmio_d = {31'd0, busy};
`ifdef MMIO_TIMER_EN
            A_TIMER: mmio_d = timer_q;
`endif
            default: mmio_d = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                if (uart_wr) begin
                    state_d = S_START;
                    shift_d = WriteData[7:0];
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_sel_q <= 1'b0;
            mmio_q    <= 32'd0;
            leds_q    <= 8'd0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            ram_sel_q <= ram_sel;
            mmio_q    <= mmio_d;
            if (MemWrite && (Address[31:2] == A_LED)) leds_q <= WriteData[7:0];
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign ReadData = ram_sel_q ? ram_rd_q : mmio_q;
    assign leds     = leds_q;
    assign uart_tx  = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mem_io
// Purpose  : Directed self-checking bench for riscv_mem_io (CLKS_PER_BIT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_io;

  localparam logic [31:0] A_LED   = 32'h1000_0000;
  localparam logic [31:0] A_UDAT  = 32'h1000_0004;
  localparam logic [31:0] A_USTA  = 32'h1000_0008;
  localparam logic [31:0] A_TIMER = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic        MemWrite = 1'b0;
  logic [31:0] ReadData;
  logic [7:0]  leds;
  logic        uart_tx;

  int n_cmp = 0;
  int n_err = 0;

  riscv_mem_io #(
    .MEM_WORDS   (1024),
    .CLKS_PER_BIT(4),
    .INIT_FILE   ("")
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .ReadData (ReadData),
    .leds     (leds),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: present the access, take the edge, settle 1 time unit later.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w);
    Address   = a;
    WriteData = d;
    MemWrite  = w;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  function automatic logic exp_tx(input int k, input logic [7:0] b);
    if (k < 4)  return 1'b0;
    if (k < 36) return b[(k - 4) / 4];
    return 1'b1;
  endfunction

  initial begin
    bus(32'd0, 32'd0, 1'b0);
    bus(32'd0, 32'd0, 1'b0);
    check_eq("rst_readdata", ReadData, 32'd0);
    check_eq("rst_leds", {24'd0, leds}, 32'd0);
    check_eq("rst_tx", {31'd0, uart_tx}, 32'd1);
    reset = 1'b0;
    bus(A_USTA, 32'd0, 1'b0);
    check_eq("rst_stat", ReadData, 32'd0);

    bus(32'h100, 32'hDEAD_BEEF, 1'b1);
    bus(32'h100, 32'd0, 1'b0);
    check_eq("ram_rd_100", ReadData, 32'hDEAD_BEEF);
    bus(32'h104, 32'h1111_1111, 1'b1);
    bus(32'h104, 32'h2222_2222, 1'b1);
    check_eq("ram_rw_old", ReadData, 32'h1111_1111);
    bus(32'h104, 32'd0, 1'b0);
    check_eq("ram_rw_new", ReadData, 32'h2222_2222);
    bus(32'h0, 32'hCAFE_0000, 1'b1);
    bus(32'hFFC, 32'h0BAD_F00D, 1'b1);
    bus(32'hFFC, 32'd0, 1'b0);
    check_eq("ram_top_word", ReadData, 32'h0BAD_F00D);

    bus(A_LED, 32'h1A5, 1'b1);
    check_eq("led_out", {24'd0, leds}, 32'hA5);
    bus(A_LED, 32'd0, 1'b0);
    check_eq("led_read", ReadData, 32'hA5);

    bus(A_UDAT, 32'h55, 1'b1);
    for (int k = 0; k < 40; k++) begin
      check_eq($sformatf("tx_k%0d", k), {31'd0, uart_tx}, {31'd0, exp_tx(k, 8'h55)});
      if (k == 20) begin
        bus(A_UDAT, 32'hFF, 1'b1);
      end else if (k == 39) begin
        bus(A_UDAT, 32'h00, 1'b1);
      end else begin
        bus(A_USTA, 32'd0, 1'b0);
        check_eq($sformatf("stat_k%0d", k), ReadData, 32'd1);
      end
    end
    for (int k = 40; k < 46; k++) begin
      check_eq($sformatf("tx_idle_k%0d", k), {31'd0, uart_tx}, 32'd1);
      bus(A_USTA, 32'd0, 1'b0);
      check_eq($sformatf("stat_idle_k%0d", k), ReadData, 32'd0);
    end
    bus(A_UDAT, 32'd0, 1'b0);
    check_eq("udat_read", ReadData, 32'd0);

    bus(A_LED, 32'hFF, 1'b1);
    bus(A_UDAT, 32'h0F, 1'b1);
    for (int k = 0; k < 15; k++) bus(32'h100, 32'd0, 1'b0);
    check_eq("pre_rst_tx", {31'd0, uart_tx}, {31'd0, exp_tx(15, 8'h0F)});
    check_eq("pre_rst_rd", ReadData, 32'hDEAD_BEEF);
    reset = 1'b1;
    bus(32'h100, 32'd0, 1'b0);
    check_eq("abort_tx", {31'd0, uart_tx}, 32'd1);
    check_eq("abort_leds", {24'd0, leds}, 32'd0);
    check_eq("abort_rd", ReadData, 32'd0);
    reset = 1'b0;
    bus(A_USTA, 32'd0, 1'b0);
    check_eq("abort_stat", ReadData, 32'd0);
    check_eq("abort_tx_hold", {31'd0, uart_tx}, 32'd1);

    bus(32'h2000_0000, 32'd0, 1'b0);
    check_eq("unmapped_rd", ReadData, 32'd0);
    bus(32'd4096, 32'd0, 1'b0);
    check_eq("ram_end_rd", ReadData, 32'd0);
    bus(32'h2000_0000, 32'h1234, 1'b1);
    bus(32'h0, 32'd0, 1'b0);
    check_eq("alias_word0", ReadData, 32'hCAFE_0000);
    bus(32'h100, 32'd0, 1'b0);
    check_eq("alias_100", ReadData, 32'hDEAD_BEEF);
    check_eq("alias_leds", {24'd0, leds}, 32'd0);
    bus(A_USTA, 32'd0, 1'b0);
    check_eq("alias_stat", ReadData, 32'd0);

`ifdef MMIO_TIMER_EN
    bus(A_TIMER, 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 10; k++) bus(32'd0, 32'd0, 1'b0);
    bus(A_TIMER, 32'd0, 1'b0);
    check_eq("timer_10", ReadData, 32'd10);
    force dut.timer_q = 32'hFFFF_FFFF;
    #1;
    release dut.timer_q;
    bus(A_TIMER, 32'd0, 1'b0);
    check_eq("timer_max", ReadData, 32'hFFFF_FFFF);
    bus(A_TIMER, 32'd0, 1'b0);
    check_eq("timer_wrap", ReadData, 32'd0);
`else
    bus(A_TIMER, 32'h1234, 1'b1);
    bus(A_TIMER, 32'd0, 1'b0);
    check_eq("timer_absent", ReadData, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
